// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC SPM control path: widths, opcodes,
// controller state encodings and bus mux select codes.
package risc_spm_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int OP_SIZE    = 4;
  localparam int STATE_SIZE = 4;
  localparam int SEL1_SIZE  = 3;
  localparam int SEL2_SIZE  = 2;

  localparam logic [OP_SIZE-1:0] OP_NOP = 4'd0;
  localparam logic [OP_SIZE-1:0] OP_ADD = 4'd1;
  localparam logic [OP_SIZE-1:0] OP_SUB = 4'd2;
  localparam logic [OP_SIZE-1:0] OP_AND = 4'd3;
  localparam logic [OP_SIZE-1:0] OP_NOT = 4'd4;
  localparam logic [OP_SIZE-1:0] OP_RD  = 4'd5;
  localparam logic [OP_SIZE-1:0] OP_WR  = 4'd6;
  localparam logic [OP_SIZE-1:0] OP_BR  = 4'd7;
  localparam logic [OP_SIZE-1:0] OP_BRZ = 4'd8;

  typedef enum logic [STATE_SIZE-1:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [SEL1_SIZE-1:0] SEL_R0 = 3'd0;
  localparam logic [SEL1_SIZE-1:0] SEL_R1 = 3'd1;
  localparam logic [SEL1_SIZE-1:0] SEL_R2 = 3'd2;
  localparam logic [SEL1_SIZE-1:0] SEL_R3 = 3'd3;
  localparam logic [SEL1_SIZE-1:0] SEL_PC = 3'd4;

  localparam logic [SEL2_SIZE-1:0] SEL_ALU  = 2'd0;
  localparam logic [SEL2_SIZE-1:0] SEL_BUS1 = 2'd1;
  localparam logic [SEL2_SIZE-1:0] SEL_MEM  = 2'd2;

  // Register-file field to one-hot load strobe vector, bit n = load_r<n>.
  function automatic logic [3:0] reg_onehot(input logic [1:0] field);
    return 4'b0001 << field;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between control_unit (master) and the
// processing_unit datapath (slave).
interface control_unit_if;
  import risc_spm_pkg::*;

  logic [WORD_SIZE-1:0] instruction;
  logic                 zero_flag;

  logic load_r0;
  logic load_r1;
  logic load_r2;
  logic load_r3;
  logic load_pc;
  logic load_y;
  logic load_z;
  logic load_ir;
  logic load_addr;
  logic inc_pc;
  logic [SEL1_SIZE-1:0] sel_bus_1_mux;
  logic [SEL2_SIZE-1:0] sel_bus_2_mux;
  logic write;
  logic halted;

  modport master (
    input  instruction, zero_flag,
    output load_r0, load_r1, load_r2, load_r3,
           load_pc, load_y, load_z, load_ir, load_addr, inc_pc,
           sel_bus_1_mux, sel_bus_2_mux, write, halted
  );

  modport slave (
    output instruction, zero_flag,
    input  load_r0, load_r1, load_r2, load_r3,
           load_pc, load_y, load_z, load_ir, load_addr, inc_pc,
           sel_bus_1_mux, sel_bus_2_mux, write, halted
  );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC SPM.
// Outputs are purely combinational from state, instruction and zero_flag.
module control_unit
  import risc_spm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  state_t state;
  state_t state_next;

  logic [OP_SIZE-1:0]   opcode;
  logic [1:0]           src;
  logic [1:0]           dest;
  logic [SEL1_SIZE-1:0] src_sel;
  logic [SEL1_SIZE-1:0] dest_sel;

  logic [3:0]           load_r;
  logic                 load_pc;
  logic                 load_y;
  logic                 load_z;
  logic                 load_ir;
  logic                 load_addr;
  logic                 inc_pc;
  logic [SEL1_SIZE-1:0] sel1;
  logic [SEL2_SIZE-1:0] sel2;
  logic                 write;
  logic                 halted;

  assign opcode   = bus.instruction[7:4];
  assign src      = bus.instruction[3:2];
  assign dest     = bus.instruction[1:0];
  assign src_sel  = {1'b0, src};
  assign dest_sel = {1'b0, dest};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: state_next = S_FET1;
      S_FET1: state_next = S_FET2;
      S_FET2: state_next = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_NOP:                 state_next = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_next = S_EX1;
          OP_NOT:                 state_next = S_FET1;
          OP_RD:                  state_next = S_RD1;
          OP_WR:                  state_next = S_WR1;
          OP_BR:                  state_next = S_BR1;
          OP_BRZ:                 state_next = bus.zero_flag ? S_BR1 : S_FET1;
          default:                state_next = S_HALT;
        endcase
      end
      S_EX1:  state_next = S_FET1;
      S_RD1:  state_next = S_RD2;
      S_RD2:  state_next = S_FET1;
      S_WR1:  state_next = S_WR2;
      S_WR2:  state_next = S_FET1;
      S_BR1:  state_next = S_BR2;
      S_BR2:  state_next = S_FET1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand-address fetch (PC onto bus_1, into the address register) is
  // shared by RD, WR, BR and taken BRZ in the decode state.
  always_comb begin
    load_r    = '0;
    load_pc   = 1'b0;
    load_y    = 1'b0;
    load_z    = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    inc_pc    = 1'b0;
    sel1      = SEL_R0;
    sel2      = SEL_ALU;
    write     = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FET1: begin
        sel1      = SEL_PC;
        sel2      = SEL_BUS1;
        load_addr = 1'b1;
      end
      S_FET2: begin
        sel2    = SEL_MEM;
        load_ir = 1'b1;
        inc_pc  = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            sel1   = src_sel;
            sel2   = SEL_BUS1;
            load_y = 1'b1;
          end
          OP_NOT: begin
            sel1   = src_sel;
            sel2   = SEL_ALU;
            load_z = 1'b1;
            load_r = reg_onehot(dest);
          end
          OP_RD, OP_WR, OP_BR: begin
            sel1      = SEL_PC;
            sel2      = SEL_BUS1;
            load_addr = 1'b1;
          end
          OP_BRZ: begin
            if (bus.zero_flag) begin
              sel1      = SEL_PC;
              sel2      = SEL_BUS1;
              load_addr = 1'b1;
            end else begin
              inc_pc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        sel1   = dest_sel;
        sel2   = SEL_ALU;
        load_z = 1'b1;
        load_r = reg_onehot(dest);
      end
      S_RD1, S_WR1: begin
        sel2      = SEL_MEM;
        load_addr = 1'b1;
        inc_pc    = 1'b1;
      end
      S_RD2: begin
        sel2   = SEL_MEM;
        load_r = reg_onehot(dest);
      end
      S_WR2: begin
        sel1  = src_sel;
        write = 1'b1;
      end
      S_BR1: begin
        sel2      = SEL_MEM;
        load_addr = 1'b1;
      end
      S_BR2: begin
        sel2    = SEL_MEM;
        load_pc = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.load_r0       = load_r[0];
  assign bus.load_r1       = load_r[1];
  assign bus.load_r2       = load_r[2];
  assign bus.load_r3       = load_r[3];
  assign bus.load_pc       = load_pc;
  assign bus.load_y        = load_y;
  assign bus.load_z        = load_z;
  assign bus.load_ir       = load_ir;
  assign bus.load_addr     = load_addr;
  assign bus.inc_pc        = inc_pc;
  assign bus.sel_bus_1_mux = sel1;
  assign bus.sel_bus_2_mux = sel2;
  assign bus.write         = write;
  assign bus.halted        = halted;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle FSM that sequences the processing_unit datapath: fetch, decode, execute for the 8-bit RISC ISA.
- Drives every register load strobe, inc_pc, both bus mux selects and the memory write strobe.
- Consumes the IR contents and the registered zero flag.
- Sits beside processing_unit and the memory in the CPU top level.

Parameters:
word_size, 8, instruction width
op_size, 4, opcode width (instruction[7:4])
state_size, 4, state register width
sel1_size, 3, bus_1 mux select width
sel2_size, 2, bus_2 mux select width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
instruction  input  word_size  IR contents: [7:4] opcode, [3:2] src, [1:0] dest
zero_flag  input  1  registered ALU zero flag
load_r0, load_r1, load_r2, load_r3  output  1 each  register file load strobes
load_pc, load_y, load_z, load_ir, load_addr  output  1 each  PC, Y, Z, IR and address register load strobes
inc_pc  output  1  PC increment strobe
sel_bus_1_mux  output  sel1_size  bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC
sel_bus_2_mux  output  sel2_size  bus_2 source: 0=ALU, 1=bus_1, 2=mem_word
write  output  1  memory write strobe (address = address register, data = bus_1)
halted  output  1  high while in S_HALT

Behaviour:
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Codes 9-15 are illegal.
- State register only, updated on posedge clk. rst low clears it to S_IDLE at once, regardless of clk.
- Outputs are combinational from state, instruction and zero_flag.
- Default for every output is 0, including all outputs in S_IDLE and during reset. Any strobe not listed for a state is 0.
- Register-select fields map sel_bus_1_mux = field value and load_r<field> = 1.

State transitions and outputs:
- S_IDLE: no strobes; -> S_FET1.
- S_FET1: sel1=PC, sel2=bus_1, load_addr; -> S_FET2.
- S_FET2: sel2=mem, load_ir, inc_pc; -> S_DEC.
- S_DEC, by opcode:
  - NOP: no strobes; -> S_FET1.
  - ADD/SUB/AND: sel1=src, sel2=bus_1, load_y; -> S_EX1.
  - NOT: sel1=src, sel2=ALU, load_z, load dest; -> S_FET1.
  - RD, WR, BR: sel1=PC, sel2=bus_1, load_addr; -> S_RD1, S_WR1 or S_BR1 respectively.
  - BRZ, zero_flag=1: same as BR; -> S_BR1.
  - BRZ, zero_flag=0: inc_pc only, skipping the operand byte; -> S_FET1.
  - Illegal opcode: -> S_HALT.
- S_EX1: sel1=dest, sel2=ALU, load_z, load dest; -> S_FET1.
- S_RD1: sel2=mem, load_addr, inc_pc; -> S_RD2.
- S_RD2: sel2=mem, load dest; -> S_FET1.
- S_WR1: sel2=mem, load_addr, inc_pc; -> S_WR2.
- S_WR2: sel1=src, write; -> S_FET1.
- S_BR1: sel2=mem, load_addr; -> S_BR2.
- S_BR2: sel2=mem, load_pc; -> S_FET1.
- S_HALT: halted=1, all strobes 0; stays until rst.
- Unused state encodings: -> S_IDLE with all strobes 0 (safe recovery).

Cycle counts per instruction, including fetch: NOP 3; ADD/SUB/AND 4; NOT 3; BRZ not-taken 3; RD, WR, BR and BRZ-taken 5.

Invariants:
- At most one load_r* asserted in any cycle.
- load_pc and inc_pc never asserted together.
- write never asserted together with any bus_2-sourced load.

Reset mid-instruction: in-flight strobes drop the same instant rst falls. Execution restarts at S_IDLE. The PC is reset by the datapath, not by this block.

Decomposition:
- Shared package risc_spm_pkg holds: opcode localparams, state encodings, bus_1 select codes (SEL_R0..SEL_PC) and bus_2 select codes (SEL_ALU, SEL_BUS1, SEL_MEM).
- No sub-module: one state register block plus one combinational next-state/output block.

Test Plan:
- Reset then NOP (instr=8'h00) -> S_IDLE, FET1, FET2, DEC, FET1. load_addr in FET1; load_ir and inc_pc in FET2; sel1=4 in FET1.
- ADD R1->R2 (8'h16) -> DEC: sel1=1, load_y. EX1: sel1=2, sel2=0, load_z, load_r2. All other strobes 0.
- BRZ (8'h80): zero_flag=0 -> DEC asserts inc_pc only and returns to FET1 (3 cycles). zero_flag=1 -> BR1 load_addr, BR2 load_pc (5 cycles).
- WR src=R3 (8'h6C) -> WR2: sel1=3, write=1, no load_* asserted. RD dest=R0 (8'h50) -> RD2: sel2=2, load_r0.
- Illegal opcode 8'hF0 -> S_HALT, halted=1, all strobes 0 for 20 cycles. rst low -> halted=0 immediately.
- Assert rst asynchronously during S_EX1 (between edges) -> load_r*/load_z drop combinationally. After release, the sequence restarts from S_IDLE.
